// File: rtl/mem_initiator_if.sv
// rtl/mem_initiator_if.sv - request/response and word-memory bus bundle for mem_initiator
interface mem_initiator_if #(
    parameter int AWIDTH = 30
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;

    logic              mem_re;
    logic              mem_we;
    logic [AWIDTH-1:0] memaddr;
    logic [31:0]       wmemdata;
    logic [31:0]       rmemdata;

    // master: the initiator itself; slave: CPU requester plus memory model
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, rmemdata,
        output req_ready, rsp_valid, rsp_rdata, mem_re, mem_we, memaddr, wmemdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, rmemdata,
        input  req_ready, rsp_valid, rsp_rdata, mem_re, mem_we, memaddr, wmemdata
    );
endinterface

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - single-outstanding load/store initiator for a fixed-latency word memory
module mem_initiator #(
    parameter int AWIDTH     = 30,
    parameter int RD_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    mem_initiator_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    // READ already spends one edge, so the wait counter covers the remainder
    localparam logic [3:0] WAIT_INIT = 4'(RD_LATENCY - 1);

    logic [2:0]        state;
    logic [3:0]        wait_cnt;
    logic              mem_re_q;
    logic              mem_we_q;
    logic [AWIDTH-1:0] memaddr_q;
    logic [31:0]       wmemdata_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;

    assign bus.req_ready = (state == S_IDLE);
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.memaddr   = memaddr_q;
    assign bus.wmemdata  = wmemdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            memaddr_q   <= '0;
            wmemdata_q  <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        memaddr_q <= bus.req_addr;
                        if (bus.req_we) begin
                            wmemdata_q <= bus.req_wdata;
                            mem_we_q   <= 1'b1;
                            state      <= S_WRITE;
                        end else begin
                            mem_re_q <= 1'b1;
                            state    <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    mem_we_q <= 1'b0;
                    state    <= S_IDLE;
                end
                S_READ: begin
                    mem_re_q <= 1'b0;
                    wait_cnt <= WAIT_INIT;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // rmemdata is only trusted on this single capture edge
                    if (wait_cnt == 4'd0) begin
                        rsp_rdata_q <= bus.rmemdata;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    mem_re_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - directed bench for mem_initiator with response scoreboard
module tb_mem_initiator;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_initiator_if #(.AWIDTH(30)) bus0 ();
    mem_initiator_if #(.AWIDTH(30)) bus1 ();

    mem_initiator #(.AWIDTH(30), .RD_LATENCY(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mem_initiator #(.AWIDTH(30), .RD_LATENCY(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // memory model, latency 1
    logic [31:0] mem0 [0:255];
    logic        v0 = 1'b0;
    logic [7:0]  a0 = 8'd0;
    always @(posedge clk) begin
        if (bus0.mem_we) mem0[bus0.memaddr[7:0]] <= bus0.wmemdata;
        v0 <= bus0.mem_re;
        a0 <= bus0.memaddr[7:0];
    end
    assign bus0.rmemdata = v0 ? mem0[a0] : 32'hzzzzzzzz;

    // memory model, latency 3
    logic [31:0] mem1 [0:15];
    logic [2:0]  v1 = 3'd0;
    logic [3:0]  a1 [0:2];
    always @(posedge clk) begin
        v1    <= {v1[1:0], bus1.mem_re};
        a1[0] <= bus1.memaddr[3:0];
        a1[1] <= a1[0];
        a1[2] <= a1[1];
    end
    assign bus1.rmemdata = v1[2] ? mem1[a1[2]] : 32'hzzzzzzzz;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    int          re_cyc [$];
    int          acc0 = 0;
    logic        re_prev0 = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // response scoreboard and bus invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            chk("re_we_excl0", {31'd0, bus0.mem_re & bus0.mem_we}, 32'd0);
            chk("re_we_excl1", {31'd0, bus1.mem_re & bus1.mem_we}, 32'd0);
            if (bus0.req_valid && bus0.req_ready) acc0++;
            if (bus0.mem_re && !re_prev0) re_cyc.push_back(cyc);
            re_prev0 = bus0.mem_re;
            if (bus0.rsp_valid && bus0.rsp_ready) begin
                checks++;
                assert (q0.size() > 0) else begin
                    errors++;
                    $error("FAIL rsp_unexp0 observed=%h expected=no response", bus0.rsp_rdata);
                end
                if (q0.size() > 0) chk("rsp_data0", bus0.rsp_rdata, q0.pop_front());
            end
            if (bus1.rsp_valid && bus1.rsp_ready) begin
                checks++;
                assert (q1.size() > 0) else begin
                    errors++;
                    $error("FAIL rsp_unexp1 observed=%h expected=no response", bus1.rsp_rdata);
                end
                if (q1.size() > 0) chk("rsp_data1", bus1.rsp_rdata, q1.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready0(input string tag);
        int n = 0;
        while (!bus0.req_ready && n < 50) begin
            step();
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL %s observed=timeout expected=req_ready", tag);
        end
    endtask

    task automatic issue0(input logic we, input logic [29:0] addr, input logic [31:0] wdata);
        bus0.req_valid = 1'b1;
        bus0.req_we    = we;
        bus0.req_addr  = addr;
        bus0.req_wdata = wdata;
        wait_ready0("issue_wait0");
        step();
        bus0.req_valid = 1'b0;
    endtask

    initial begin
        int acc_base;
        int re_base;
        for (int i = 0; i < 256; i++) mem0[i] = 32'h0;
        for (int i = 0; i < 16; i++) mem1[i] = 32'h0;
        mem0[8'h10] = 32'hDEADBEEF;
        mem0[8'h30] = 32'hCAFEF00D;
        mem0[0] = 32'hA0;
        mem0[1] = 32'hA1;
        mem0[2] = 32'hA2;
        mem1[5] = 32'h55AA55AA;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus0.rsp_ready = 1'b1;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        bus1.rsp_ready = 1'b1;

        // reset state
        step(); step();
        chk("rst_req_ready", {31'd0, bus0.req_ready}, 32'd1);
        chk("rst_mem_re",    {31'd0, bus0.mem_re},    32'd0);
        chk("rst_mem_we",    {31'd0, bus0.mem_we},    32'd0);
        chk("rst_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
        chk("rst_memaddr",   {2'd0, bus0.memaddr},    32'd0);
        chk("rst_wmemdata",  bus0.wmemdata,           32'd0);
        chk("rst_rsp_rdata", bus0.rsp_rdata,          32'd0);
        rst = 1'b1;
        step();

        // 1: single load, latency 1
        q0.push_back(32'hDEADBEEF);
        issue0(1'b0, 30'h010, 32'h0);
        chk("t1_mem_re_e0",   {31'd0, bus0.mem_re},    32'd1);
        chk("t1_memaddr",     {2'd0, bus0.memaddr},    32'h010);
        chk("t1_req_ready",   {31'd0, bus0.req_ready}, 32'd0);
        step();
        chk("t1_mem_re_e1",   {31'd0, bus0.mem_re},    32'd0);
        chk("t1_rsp_early",   {31'd0, bus0.rsp_valid}, 32'd0);
        step();
        chk("t1_rsp_e2",      {31'd0, bus0.rsp_valid}, 32'd1);
        chk("t1_rdata",       bus0.rsp_rdata,          32'hDEADBEEF);
        step();
        chk("t1_rsp_drop",    {31'd0, bus0.rsp_valid}, 32'd0);
        chk("t1_ready_back",  {31'd0, bus0.req_ready}, 32'd1);

        // 2: store then load back
        issue0(1'b1, 30'h020, 32'h12345678);
        chk("t2_mem_we",      {31'd0, bus0.mem_we},    32'd1);
        chk("t2_mem_re",      {31'd0, bus0.mem_re},    32'd0);
        chk("t2_wmemdata",    bus0.wmemdata,           32'h12345678);
        chk("t2_memaddr",     {2'd0, bus0.memaddr},    32'h020);
        chk("t2_busy",        {31'd0, bus0.req_ready}, 32'd0);
        step();
        chk("t2_we_drop",     {31'd0, bus0.mem_we},    32'd0);
        chk("t2_ready_e1",    {31'd0, bus0.req_ready}, 32'd1);
        chk("t2_no_rsp",      {31'd0, bus0.rsp_valid}, 32'd0);
        q0.push_back(32'h12345678);
        issue0(1'b0, 30'h020, 32'h0);
        step(); step();
        chk("t2_load_rsp",    {31'd0, bus0.rsp_valid}, 32'd1);
        step();

        // 3: back-pressured response
        bus0.rsp_ready = 1'b0;
        q0.push_back(32'hCAFEF00D);
        issue0(1'b0, 30'h030, 32'h0);
        step(); step();
        for (int i = 0; i < 5; i++) begin
            chk("t3_rsp_hold",  {31'd0, bus0.rsp_valid}, 32'd1);
            chk("t3_rdata",     bus0.rsp_rdata,          32'hCAFEF00D);
            chk("t3_ready_low", {31'd0, bus0.req_ready}, 32'd0);
            chk("t3_quiet",     {30'd0, bus0.mem_re, bus0.mem_we}, 32'd0);
            step();
        end
        bus0.rsp_ready = 1'b1;
        step();
        chk("t3_ready_after", {31'd0, bus0.req_ready}, 32'd1);
        chk("t3_rsp_done",    {31'd0, bus0.rsp_valid}, 32'd0);

        // 4: back-to-back loads with req_valid held
        acc_base = acc0;
        re_base  = re_cyc.size();
        bus0.req_valid = 1'b1;
        bus0.req_we    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus0.req_addr = 30'(i);
            q0.push_back(32'hA0 + 32'(i));
            wait_ready0("t4_wait");
            step();
        end
        bus0.req_valid = 1'b0;
        wait_ready0("t4_drain");
        step();
        chk("t4_accepts",  32'(acc0 - acc_base),            32'd3);
        chk("t4_re_count", 32'(re_cyc.size() - re_base),   32'd3);
        if (re_cyc.size() - re_base == 3) begin
            chk("t4_gap01", 32'(re_cyc[re_base+1] - re_cyc[re_base]),   32'd4);
            chk("t4_gap12", 32'(re_cyc[re_base+2] - re_cyc[re_base+1]), 32'd4);
        end
        chk("t4_q_empty", 32'(q0.size()), 32'd0);

        // 5: latency 3 on the second instance
        q1.push_back(32'h55AA55AA);
        bus1.req_valid = 1'b1;
        bus1.req_we    = 1'b0;
        bus1.req_addr  = 30'h5;
        step();
        bus1.req_valid = 1'b0;
        chk("t5_mem_re",   {31'd0, bus1.mem_re},    32'd1);
        step();
        chk("t5_e1",       {31'd0, bus1.rsp_valid}, 32'd0);
        step();
        chk("t5_e2",       {31'd0, bus1.rsp_valid}, 32'd0);
        step();
        chk("t5_e3",       {31'd0, bus1.rsp_valid}, 32'd0);
        step();
        chk("t5_e4",       {31'd0, bus1.rsp_valid}, 32'd1);
        chk("t5_rdata",    bus1.rsp_rdata,          32'h55AA55AA);
        step();
        chk("t5_done",     {31'd0, bus1.rsp_valid}, 32'd0);
        chk("t5_q_empty",  32'(q1.size()),          32'd0);

        // 6: reset while waiting for read data; the load is abandoned
        bus1.req_valid = 1'b1;
        bus1.req_addr  = 30'h5;
        step();
        bus1.req_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        chk("t6_mem_re",    {31'd0, bus1.mem_re},    32'd0);
        chk("t6_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
        chk("t6_ready",     {31'd0, bus1.req_ready}, 32'd1);
        chk("t6_memaddr",   {2'd0, bus1.memaddr},    32'd0);
        step();
        rst = 1'b1;
        step();
        chk("t6_ready_rel", {31'd0, bus1.req_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t6_no_stale", {31'd0, bus1.rsp_valid}, 32'd0);
            step();
        end
        chk("end_q0_empty", 32'(q0.size()), 32'd0);
        chk("end_q1_empty", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
